// File: rtl/hazard_controller.sv
// hazard_controller: load-use/branch stalls, redirects, I-miss deferral, D-miss freeze (optional perf counters: HAZARD_PERF_CNT_EN)
module hazard_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      IF_ID_rs1,
    input  logic [4:0]      IF_ID_rs2,
    input  logic            IF_ID_use_rs1,
    input  logic            IF_ID_use_rs2,
    input  logic            branch_id,
    input  logic [4:0]      ID_EX_rd,
    input  logic            ID_EX_regwrite,
    input  logic            ID_EX_memread,
    input  logic [4:0]      EX_MEM_rd,
    input  logic            EX_MEM_memread,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            ICACHE_stall,
    input  logic            DCACHE_stall,
    output logic            PC_write,
    output logic [1:0]      pc_sel,
    output logic [XLEN-1:0] redirect_pc,
    output logic            IF_ID_write,
    output logic            IF_ID_flush,
    output logic            ID_EX_write,
    output logic            ID_EX_bubble,
    output logic            EX_MEM_write,
    output logic            MEM_WB_write
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);
    typedef enum logic [1:0] {RUN, IMISS, IMISS_REDIR} state_t;
    state_t state, state_nxt;
    logic   load_rpc, applied;
    logic   m_ex, m_mem, hz_lu, hz_br;

    assign m_ex  = (IF_ID_use_rs1 && IF_ID_rs1 == ID_EX_rd) || (IF_ID_use_rs2 && IF_ID_rs2 == ID_EX_rd);
    assign m_mem = (IF_ID_use_rs1 && IF_ID_rs1 == EX_MEM_rd) || (IF_ID_use_rs2 && IF_ID_rs2 == EX_MEM_rd);
    assign hz_lu = ID_EX_memread && ID_EX_rd != 5'd0 && m_ex;
    assign hz_br = branch_id && ((ID_EX_regwrite && ID_EX_rd != 5'd0 && m_ex) ||
                                 (EX_MEM_memread && EX_MEM_rd != 5'd0 && m_mem));

    // Prioritised pipeline control and next-state selection
    always_comb begin
        PC_write     = 1'b1;
        pc_sel       = 2'd0;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        state_nxt    = (state == IMISS && !ICACHE_stall) ? RUN : state;
        load_rpc     = 1'b0;
        applied      = 1'b0;
        if (rst) begin
            {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = 5'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            state_nxt    = RUN;
        end else if (DCACHE_stall) begin
            {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = 5'b0;
            state_nxt = state;
        end else if (state == IMISS_REDIR && !ICACHE_stall) begin
            pc_sel      = 2'd2;
            IF_ID_flush = 1'b1;
            state_nxt   = RUN;
            applied     = 1'b1;
        end else if (hz_lu || hz_br) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (redirect && !ICACHE_stall) begin
            pc_sel      = 2'd1;
            IF_ID_flush = 1'b1;
            applied     = 1'b1;
        end else if (redirect) begin
            PC_write    = 1'b0;
            IF_ID_flush = 1'b1;
            load_rpc    = 1'b1;
            state_nxt   = IMISS_REDIR;
        end else if (ICACHE_stall) begin
            PC_write    = 1'b0;
            IF_ID_flush = 1'b1;
            state_nxt   = (state == IMISS_REDIR) ? IMISS_REDIR : IMISS;
        end
    end

    // State and deferred redirect target
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            if (load_rpc) redirect_pc <= redirect_target;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Stall-cycle and applied-redirect counters, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!PC_write) stall_cycles <= stall_cycles + 32'd1;
            if (applied) flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule
